ni_packetizer: RTL and testbench

Network-interface transmit side for a router's local input port. Takes a packet request (destination, length) plus a stream of payload words. Emits HEADER / BODY / TAIL flits with the flit_type encodings that the router's route computation decodes. Flow control toward the local input FIFO is credit-based, so no flit is ever sent into a full buffer.

---
 rtl/ni_packetizer.sv | 181 ++++++++++++++++++
 tb/tb_ni_packetizer.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ni_packetizer.sv
// ni_packetizer: NI transmit side. Turns a (dst, len) request plus a payload stream into HEADER/BODY/TAIL
// flits under credit flow control. Define NI_SEQ_NUM_EN to carry a per-packet sequence number in the header.
`timescale 1ns/1ps
`ifndef AXIS
`define AXIS 4
`endif

module ni_packetizer #(
    parameter int DATA_WIDTH = 32,
    parameter int LEN_W      = 5,
    parameter int MAX_LEN    = 16,
    parameter int CREDITS    = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [`AXIS-1:0]        cur_addr_rst,
    input  logic                    pkt_req,
    input  logic [`AXIS-1:0]        pkt_dst,
    input  logic [LEN_W-1:0]        pkt_len,
    output logic                    pkt_ack,
    input  logic [DATA_WIDTH-1:0]   pld_data,
    input  logic                    pld_valid,
    output logic                    pld_ready,
    output logic [DATA_WIDTH+2:0]   flit_out,
    output logic                    flit_valid,
    input  logic                    credit_in,
    output logic                    busy
);

    localparam int AW      = `AXIS;
    localparam int CW      = $clog2(CREDITS + 1);
    localparam int SEQ_LSB = 2 * AW + LEN_W;

    localparam logic [2:0] FT_HEADER = 3'b001;
    localparam logic [2:0] FT_BODY   = 3'b010;
    localparam logic [2:0] FT_TAIL   = 3'b100;

    localparam logic [CW-1:0]    CREDIT_MAX = CW'(CREDITS);
    localparam logic [LEN_W-1:0] LEN_MAX    = LEN_W'(MAX_LEN);

    typedef enum logic [1:0] {IDLE, HDR, PLD} state_t;

    state_t                  state_q, state_d;
    logic [CW-1:0]           credit_q, credit_d;
    logic [LEN_W-1:0]        rem_q, rem_d;
    logic [LEN_W-1:0]        len_q, len_d;
    logic [AW-1:0]           dst_q, dst_d;
    logic [AW-1:0]           cur_addr_q;
    logic [DATA_WIDTH+2:0]   flit_q, flit_d;
    logic                    flit_valid_q, flit_valid_d;
    logic                    ack_q, ack_d;
    logic [7:0]              seq_val;
    logic                    can_send;
    logic [DATA_WIDTH-1:0]   hdr_payload;

    function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] len);
        return (len > LEN_MAX) ? LEN_MAX : len;
    endfunction

`ifdef NI_SEQ_NUM_EN
    logic [7:0] seq_q, seq_d;

    // Advances once per header actually sent; wraps naturally at 8 bits.
    always_comb begin
        seq_d = seq_q;
        if (state_q == HDR && can_send) begin
            seq_d = seq_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            seq_q <= 8'd0;
        end else begin
            seq_q <= seq_d;
        end
    end

    assign seq_val = seq_q;
`else
    assign seq_val = 8'd0;
`endif

    always_comb begin
        hdr_payload                      = '0;
        hdr_payload[AW-1:0]              = dst_q;
        hdr_payload[2*AW-1:AW]           = cur_addr_q;
        hdr_payload[SEQ_LSB-1:2*AW]      = len_q;
        hdr_payload[SEQ_LSB +: 8]        = seq_val;
    end

    assign can_send  = (credit_q != '0);
    assign pld_ready = (state_q == PLD) && can_send && (rem_q != '0);

    always_comb begin
        state_d      = state_q;
        rem_d        = rem_q;
        len_d        = len_q;
        dst_d        = dst_q;
        flit_d       = flit_q;
        flit_valid_d = 1'b0;
        ack_d        = 1'b0;
        case (state_q)
            IDLE: begin
                if (pkt_req) begin
                    dst_d   = pkt_dst;
                    len_d   = clamp_len(pkt_len);
                    rem_d   = clamp_len(pkt_len);
                    ack_d   = 1'b1;
                    state_d = HDR;
                end
            end
            HDR: begin
                if (can_send) begin
                    flit_d       = {FT_HEADER, hdr_payload};
                    flit_valid_d = 1'b1;
                    state_d      = PLD;
                end
            end
            PLD: begin
                // A zero-length packet still needs a TAIL to close the route.
                if (rem_q == '0) begin
                    if (can_send) begin
                        flit_d       = {FT_TAIL, {DATA_WIDTH{1'b0}}};
                        flit_valid_d = 1'b1;
                        state_d      = IDLE;
                    end
                end else if (pld_valid && pld_ready) begin
                    flit_valid_d = 1'b1;
                    rem_d        = rem_q - LEN_W'(1);
                    if (rem_q == LEN_W'(1)) begin
                        flit_d  = {FT_TAIL, pld_data};
                        state_d = IDLE;
                    end else begin
                        flit_d  = {FT_BODY, pld_data};
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Send and return in the same cycle cancel; returns beyond the FIFO depth are dropped.
    always_comb begin
        credit_d = credit_q;
        if (flit_valid_d && !credit_in) begin
            credit_d = credit_q - CW'(1);
        end else if (!flit_valid_d && credit_in && credit_q != CREDIT_MAX) begin
            credit_d = credit_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            credit_q     <= CREDIT_MAX;
            rem_q        <= '0;
            len_q        <= '0;
            dst_q        <= '0;
            cur_addr_q   <= cur_addr_rst;
            flit_q       <= '0;
            flit_valid_q <= 1'b0;
            ack_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            credit_q     <= credit_d;
            rem_q        <= rem_d;
            len_q        <= len_d;
            dst_q        <= dst_d;
            flit_q       <= flit_d;
            flit_valid_q <= flit_valid_d;
            ack_q        <= ack_d;
        end
    end

    assign flit_out   = flit_q;
    assign flit_valid = flit_valid_q;
    assign pkt_ack    = ack_q;
    assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_ni_packetizer.sv
// tb_ni_packetizer: directed bench for ni_packetizer with hand-computed flit expectations.
`timescale 1ns/1ps
`ifndef AXIS
`define AXIS 4
`endif

module tb_ni_packetizer;

    localparam int DW = 32;
    localparam int LW = 5;
    localparam int A  = `AXIS;
    localparam logic [2:0] T_HDR  = 3'b001;
    localparam logic [2:0] T_BODY = 3'b010;
    localparam logic [2:0] T_TAIL = 3'b100;
`ifdef NI_SEQ_NUM_EN
    localparam bit SEQ_ON = 1'b1;
`else
    localparam bit SEQ_ON = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic [A-1:0]    cur_addr_rst = 4'b0100;
    logic            pkt_req = 1'b0;
    logic [A-1:0]    pkt_dst = '0;
    logic [LW-1:0]   pkt_len = '0;
    logic            pkt_ack;
    logic [DW-1:0]   pld_data;
    logic            pld_valid = 1'b0;
    logic            pld_ready;
    logic [DW+2:0]   flit_out;
    logic            flit_valid;
    logic            credit_in = 1'b0;
    logic            busy;

    always #5 clk = ~clk;

    ni_packetizer #(.DATA_WIDTH(DW), .LEN_W(LW), .MAX_LEN(16), .CREDITS(4)) dut (
        .clk(clk), .rst(rst), .cur_addr_rst(cur_addr_rst),
        .pkt_req(pkt_req), .pkt_dst(pkt_dst), .pkt_len(pkt_len), .pkt_ack(pkt_ack),
        .pld_data(pld_data), .pld_valid(pld_valid), .pld_ready(pld_ready),
        .flit_out(flit_out), .flit_valid(flit_valid), .credit_in(credit_in), .busy(busy)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Flit capture and payload source
    logic [DW+2:0]  fq[$];
    int             fcyc[$];
    int             cyc = 0;
    int             rdy_cnt = 0;
    int             pidx = 0;
    int             pidx0 = 0;
    logic [DW-1:0]  pld_base = '0;

    assign pld_data = pld_base + DW'(pidx - pidx0);

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (pld_valid && pld_ready) pidx <= pidx + 1;
    end

    always @(negedge clk) begin
        if (flit_valid) begin
            fq.push_back(flit_out);
            fcyc.push_back(cyc);
        end
        if (pld_ready) rdy_cnt <= rdy_cnt + 1;
    end

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0; pkt_req = 1'b0; pld_valid = 1'b0; credit_in = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic request(input logic [A-1:0] dst, input logic [LW-1:0] len);
        bit got;
        got = 1'b0;
        @(negedge clk);
        pkt_dst = dst; pkt_len = len; pkt_req = 1'b1;
        for (int i = 0; i < 10 && !got; i++) begin
            @(negedge clk);
            if (pkt_ack) got = 1'b1;
        end
        pkt_req = 1'b0;
        check("ack_seen", 64'(got), 64'd1);
    endtask

    task automatic wait_idle(input int bound);
        bit done;
        done = 1'b0;
        for (int i = 0; i < bound && !done; i++) begin
            @(negedge clk); #1;
            if (!busy && !flit_valid) done = 1'b1;
        end
        check("idle_reached", 64'(done), 64'd1);
    endtask

    initial begin
        int f0;
        int r0;
        int p0;
        bit hit;

        // Reset state
        do_reset();
        #1;
        check("rst_flit_valid", 64'(flit_valid), 64'd0);
        check("rst_pkt_ack", 64'(pkt_ack), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_flit_out", 64'(flit_out), 64'd0);
        check("rst_credits", 64'(dut.credit_q), 64'd4);

        // 1: normal packet dst=1 len=2 payload 0xA,0xB
        pld_base = 32'hA; pidx0 = pidx; pld_valid = 1'b1;
        f0 = fq.size();
        request(4'b0001, 5'd2);
        wait_idle(20);
        check("t1_count", 64'(fq.size() - f0), 64'd3);
        if (fq.size() - f0 >= 3) begin
            check("t1_header", 64'(fq[f0]), 64'({T_HDR, 32'h0000_0241}));
            check("t1_body", 64'(fq[f0+1]), 64'({T_BODY, 32'h0000_000A}));
            check("t1_tail", 64'(fq[f0+2]), 64'({T_TAIL, 32'h0000_000B}));
            check("t1_back_to_back", 64'(fcyc[f0+2] - fcyc[f0]), 64'd2);
        end
        check("t1_credits", 64'(dut.credit_q), 64'd1);
        check("t1_busy", 64'(busy), 64'd0);

        // 2: credit stall, len=6, no returns
        do_reset();
        pld_base = 32'h10; pidx0 = pidx; pld_valid = 1'b1;
        f0 = fq.size();
        request(4'b0010, 5'd6);
        repeat (8) @(negedge clk);
        #1;
        check("t2_stall_count", 64'(fq.size() - f0), 64'd4);
        check("t2_stall_valid", 64'(flit_valid), 64'd0);
        check("t2_stall_ready", 64'(pld_ready), 64'd0);
        credit_in = 1'b1;
        @(negedge clk);
        credit_in = 1'b0;
        #1;
        check("t2_not_yet", 64'(flit_valid), 64'd0);
        @(negedge clk); #1;
        check("t2_one_valid", 64'(flit_valid), 64'd1);
        check("t2_one_body", 64'(flit_out), 64'({T_BODY, 32'h0000_0013}));
        repeat (4) @(negedge clk);
        #1;
        check("t2_one_only", 64'(fq.size() - f0), 64'd5);
        credit_in = 1'b1;
        wait_idle(40);
        credit_in = 1'b0;

        // 3: credit return with every send, len=8
        do_reset();
        pld_base = 32'h100; pidx0 = pidx; pld_valid = 1'b1; credit_in = 1'b1;
        f0 = fq.size();
        request(4'b0011, 5'd8);
        wait_idle(40);
        check("t3_count", 64'(fq.size() - f0), 64'd9);
        if (fq.size() - f0 >= 9) begin
            check("t3_no_stall", 64'(fcyc[f0+8] - fcyc[f0]), 64'd8);
            check("t3_tail", 64'(fq[f0+8]), 64'({T_TAIL, 32'h0000_0107}));
        end
        repeat (3) @(negedge clk);
        #1;
        check("t3_credits_sat", 64'(dut.credit_q), 64'd4);

        // 4: zero-length packet, then clamped len=31
        do_reset();
        pld_base = 32'h200; pidx0 = pidx; pld_valid = 1'b1; credit_in = 1'b1;
        f0 = fq.size(); r0 = rdy_cnt; p0 = pidx;
        request(4'b0101, 5'd0);
        wait_idle(20);
        check("t4_len0_count", 64'(fq.size() - f0), 64'd2);
        if (fq.size() - f0 >= 2) begin
            check("t4_len0_header", 64'(fq[f0]), 64'({T_HDR, 32'h0000_0045}));
            check("t4_len0_tail", 64'(fq[f0+1]), 64'({T_TAIL, 32'h0}));
        end
        check("t4_len0_no_ready", 64'(rdy_cnt - r0), 64'd0);
        check("t4_len0_no_consume", 64'(pidx - p0), 64'd0);
        f0 = fq.size();
        request(4'b0100, 5'd31);
        wait_idle(60);
        check("t4_clamp_count", 64'(fq.size() - f0), 64'd17);
        if (fq.size() - f0 >= 17) begin
            check("t4_clamp_header", 64'(fq[f0]),
                  64'({T_HDR, 32'h0000_1044 | (SEQ_ON ? 32'h0000_2000 : 32'h0)}));
            check("t4_clamp_tail", 64'(fq[f0+16]), 64'({T_TAIL, 32'h0000_020F}));
        end
        credit_in = 1'b0;

        // 5: reset in the middle of a packet
        do_reset();
        pld_base = 32'h300; pidx0 = pidx; pld_valid = 1'b1; credit_in = 1'b1;
        f0 = fq.size();
        request(4'b0110, 5'd6);
        hit = 1'b0;
        for (int i = 0; i < 20 && !hit; i++) begin
            @(negedge clk); #1;
            if (fq.size() - f0 >= 3) hit = 1'b1;
        end
        check("t5_two_bodies", 64'(hit), 64'd1);
        rst = 1'b0;
        #1;
        check("t5_rst_valid", 64'(flit_valid), 64'd0);
        check("t5_rst_busy", 64'(busy), 64'd0);
        check("t5_rst_credits", 64'(dut.credit_q), 64'd4);
        @(negedge clk);
        rst = 1'b1;
        f0 = fq.size();
        request(4'b0111, 5'd1);
        wait_idle(20);
        check("t5_new_count", 64'(fq.size() - f0), 64'd2);
        if (fq.size() - f0 >= 1) begin
            check("t5_new_header", 64'(fq[f0]), 64'({T_HDR, 32'h0000_0147}));
        end

        // 6: sequence field over 257 packets
        do_reset();
        pld_valid = 1'b0; credit_in = 1'b1;
        for (int p = 0; p < 257; p++) begin
            f0 = fq.size();
            request(4'b0001, 5'd0);
            wait_idle(20);
            if (fq.size() > f0) begin
                check($sformatf("t6_seq_%0d", p), 64'(fq[f0][20:13]),
                      64'(SEQ_ON ? (p % 256) : 0));
            end else begin
                check($sformatf("t6_hdr_%0d", p), 64'(fq.size() - f0), 64'd2);
            end
        end
        credit_in = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
